// File: rtl/dpram_bus_port.sv
// Bus responder for one port of the dual-port RAM: turns access/ack transactions into RAM cycles,
// covering the one-cycle registered read latency and doing byte-lane writes as read-modify-write.
module dpram_bus_port #(
    parameter int words = 8192,
    localparam int addr_bits = $clog2(words)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs,
    input  logic                 data_m_access,
    output logic                 data_m_ack,
    input  logic                 data_m_wr_en,
    input  logic [addr_bits-1:0] data_m_addr,
    input  logic [1:0]           data_m_bytesel,
    input  logic [15:0]          data_m_data_in,
    output logic [15:0]          data_m_data_out,
    output logic [addr_bits-1:0] ram_addr,
    output logic                 ram_wr_en,
    output logic [15:0]          ram_wdata,
    input  logic [15:0]          ram_q
);

    // state  | meaning
    // IDLE   | waiting for cs && access; request captured on accept
    // RD     | captured address presented; RAM registers read data at end of cycle
    // WAIT   | ram_q valid; read completes or partial-write merge is built
    // WR     | RAM write (suppressed for bytesel 00); ack raised
    // ACK    | ack high for one cycle; access not sampled
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_ACK} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_accept;
    logic                   w_partial;

    logic [addr_bits-1:0]   r_addr;
    logic                   r_wr;
    logic [1:0]             r_bytesel;
    logic [15:0]            r_din;
    logic [15:0]            r_merge;
    logic                   r_ack;
    logic [15:0]            r_dout;

    assign w_partial = (data_m_bytesel == 2'b01) || (data_m_bytesel == 2'b10);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cs && data_m_access) begin
                    w_accept = 1'b1;
                    if (!data_m_wr_en || w_partial) w_state_next = S_RD;
                    else                            w_state_next = S_WR;
                end
            end
            S_RD:    w_state_next = S_WAIT;
            S_WAIT:  w_state_next = r_wr ? S_WR : S_ACK;
            S_WR:    w_state_next = S_ACK;
            S_ACK:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr    <= '0;
            r_wr      <= 1'b0;
            r_bytesel <= 2'b00;
            r_din     <= 16'h0000;
            r_merge   <= 16'h0000;
            r_ack     <= 1'b0;
            r_dout    <= 16'h0000;
        end else begin
            r_ack <= 1'b0;
            if (w_accept) begin
                r_addr    <= data_m_addr;
                r_wr      <= data_m_wr_en;
                r_bytesel <= data_m_bytesel;
                r_din     <= data_m_data_in;
            end
            if (r_state == S_WAIT) begin
                if (!r_wr) begin
                    r_dout <= ram_q;
                    r_ack  <= 1'b1;
                end else begin
                    // unselected lanes keep the current RAM contents
                    r_merge[15:8] <= r_bytesel[1] ? r_din[15:8] : ram_q[15:8];
                    r_merge[7:0]  <= r_bytesel[0] ? r_din[7:0]  : ram_q[7:0];
                end
            end
            if (r_state == S_WR) r_ack <= 1'b1;
        end
    end

    // write enable decodes straight from state so reset kills it immediately
    assign ram_wr_en       = (r_state == S_WR) && (r_bytesel != 2'b00);
    assign ram_wdata       = (r_bytesel == 2'b11) ? r_din : r_merge;
    assign ram_addr        = r_addr;
    assign data_m_ack      = r_ack;
    assign data_m_data_out = r_dout;

endmodule

// File: tb/tb_dpram_bus_port.sv
// Directed bench for dpram_bus_port with a behavioural synchronous RAM on the port side.
module tb_dpram_bus_port;

    localparam int WORDS = 8192;
    localparam int AB    = $clog2(WORDS);

    logic          clk = 1'b0;
    logic          reset;
    logic          cs;
    logic          data_m_access;
    logic          data_m_ack;
    logic          data_m_wr_en;
    logic [AB-1:0] data_m_addr;
    logic [1:0]    data_m_bytesel;
    logic [15:0]   data_m_data_in;
    logic [15:0]   data_m_data_out;
    logic [AB-1:0] ram_addr;
    logic          ram_wr_en;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_q;

    logic          pl_en;
    logic [AB-1:0] pl_addr;
    logic [15:0]   pl_data;
    logic [15:0]   mem [0:WORDS-1];

    int n_pass  = 0;
    int n_total = 0;

    dpram_bus_port #(.words(WORDS)) dut (
        .clk(clk), .reset(reset), .cs(cs),
        .data_m_access(data_m_access), .data_m_ack(data_m_ack),
        .data_m_wr_en(data_m_wr_en), .data_m_addr(data_m_addr),
        .data_m_bytesel(data_m_bytesel), .data_m_data_in(data_m_data_in),
        .data_m_data_out(data_m_data_out), .ram_addr(ram_addr),
        .ram_wr_en(ram_wr_en), .ram_wdata(ram_wdata), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en)          mem[pl_addr]  <= pl_data;
        else if (ram_wr_en) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    task automatic preload(input logic [AB-1:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // ack_n / we_n: cycle index after the sampling edge (1 = first cycle after it), -1 if never seen
    task automatic run_access(input logic wr, input logic [AB-1:0] a, input logic [1:0] bs,
                              input logic [15:0] din, output int ack_n, output int we_n);
        ack_n = -1;
        we_n  = -1;
        @(negedge clk);
        cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = wr;
        data_m_addr = a; data_m_bytesel = bs; data_m_data_in = din;
        @(posedge clk);
        for (int n = 1; n <= 12; n++) begin
            #1;
            if (n == 1) begin
                data_m_addr    = ~a;
                data_m_data_in = ~din;
            end
            if (ram_wr_en && we_n < 0) we_n = n;
            if (data_m_ack) begin
                ack_n = n;
                break;
            end
            @(posedge clk);
        end
        data_m_access = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset_values;
        n_total++;
        if ({data_m_ack, ram_wr_en} !== 2'b00) $display("FAIL reset_ctl ack/we=%b expected 00", {data_m_ack, ram_wr_en});
        else n_pass++;
        n_total++;
        if ({data_m_data_out, ram_wdata} !== 32'h0) $display("FAIL reset_data dout/wdata=%h expected 0", {data_m_data_out, ram_wdata});
        else n_pass++;
        n_total++;
        if (ram_addr !== '0) $display("FAIL reset_addr got %h expected 0", ram_addr);
        else n_pass++;
    endtask

    task automatic test_full_write_read;
        int an, wn;
        run_access(1'b1, 13'd5, 2'b11, 16'hBEEF, an, wn);
        n_total++;
        if (an !== 2 || wn !== 1) $display("FAIL full_wr_timing ack=%0d we=%0d expected 2/1", an, wn);
        else n_pass++;
        n_total++;
        if (mem[5] !== 16'hBEEF) $display("FAIL full_wr_mem got %h expected beef", mem[5]);
        else n_pass++;
        run_access(1'b0, 13'd5, 2'b11, 16'h0000, an, wn);
        n_total++;
        if (an !== 3 || wn !== -1) $display("FAIL read_timing ack=%0d we=%0d expected 3/-1", an, wn);
        else n_pass++;
        n_total++;
        if (data_m_data_out !== 16'hBEEF) $display("FAIL read_data got %h expected beef", data_m_data_out);
        else n_pass++;
    endtask

    task automatic test_partial_write;
        int an, wn;
        run_access(1'b1, 13'd7, 2'b01, 16'hAACC, an, wn);
        n_total++;
        if (an !== 4 || wn !== 3) $display("FAIL part_lo_timing ack=%0d we=%0d expected 4/3", an, wn);
        else n_pass++;
        n_total++;
        if (mem[7] !== 16'h12CC) $display("FAIL part_lo_mem got %h expected 12cc", mem[7]);
        else n_pass++;
        run_access(1'b1, 13'd7, 2'b10, 16'h5577, an, wn);
        n_total++;
        if (an !== 4 || wn !== 3) $display("FAIL part_hi_timing ack=%0d we=%0d expected 4/3", an, wn);
        else n_pass++;
        n_total++;
        if (mem[7] !== 16'h55CC) $display("FAIL part_hi_mem got %h expected 55cc", mem[7]);
        else n_pass++;
        n_total++;
        if (data_m_data_out !== 16'hBEEF) $display("FAIL dout_held got %h expected beef", data_m_data_out);
        else n_pass++;
        run_access(1'b0, 13'd7, 2'b00, 16'h0000, an, wn);
        n_total++;
        if (an !== 3 || data_m_data_out !== 16'h55CC) $display("FAIL read_bs00 ack=%0d data=%h expected 3/55cc", an, data_m_data_out);
        else n_pass++;
    endtask

    task automatic test_noop_cs;
        int an, wn;
        int acks, wes;
        run_access(1'b1, 13'd3, 2'b00, 16'h9999, an, wn);
        n_total++;
        if (an !== 2 || wn !== -1) $display("FAIL noop_timing ack=%0d we=%0d expected 2/-1", an, wn);
        else n_pass++;
        n_total++;
        if (mem[3] !== 16'h3333) $display("FAIL noop_mem got %h expected 3333", mem[3]);
        else n_pass++;
        acks = 0; wes = 0;
        @(negedge clk);
        cs = 1'b0; data_m_access = 1'b1; data_m_wr_en = 1'b1;
        data_m_addr = 13'd3; data_m_bytesel = 2'b11; data_m_data_in = 16'h9999;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (data_m_ack) acks++;
            if (ram_wr_en)  wes++;
        end
        data_m_access = 1'b0; cs = 1'b1;
        n_total++;
        if (acks !== 0 || wes !== 0) $display("FAIL cs_low acks=%0d wes=%0d expected 0/0", acks, wes);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int acks, first_n, second_n;
        logic [15:0] d1, d2;
        acks = 0; first_n = -1; second_n = -1; d1 = '0; d2 = '0;
        @(negedge clk);
        cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b0;
        data_m_addr = 13'd0; data_m_bytesel = 2'b11; data_m_data_in = 16'h0;
        @(posedge clk);
        for (int n = 1; n <= 12; n++) begin
            #1;
            if (data_m_ack) begin
                acks++;
                if (first_n < 0) begin
                    first_n = n; d1 = data_m_data_out;
                    data_m_addr = AB'(WORDS - 1);
                end else if (second_n < 0) begin
                    second_n = n; d2 = data_m_data_out;
                    data_m_access = 1'b0;
                end
            end
            @(posedge clk);
        end
        data_m_access = 1'b0;
        n_total++;
        if (acks !== 2 || first_n !== 3 || second_n !== 7)
            $display("FAIL b2b_timing acks=%0d first=%0d second=%0d expected 2/3/7", acks, first_n, second_n);
        else n_pass++;
        n_total++;
        if (d1 !== 16'h0A0B || d2 !== 16'hF00D) $display("FAIL b2b_data got %h/%h expected 0a0b/f00d", d1, d2);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write;
        int acks, wes, an, wn;
        acks = 0; wes = 0;
        @(negedge clk);
        cs = 1'b1; data_m_access = 1'b1; data_m_wr_en = 1'b1;
        data_m_addr = 13'd9; data_m_bytesel = 2'b01; data_m_data_in = 16'h00FF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_total++;
        if ({data_m_ack, ram_wr_en, ram_addr, ram_wdata, data_m_data_out} !== '0)
            $display("FAIL rst_async_outs ack=%b we=%b addr=%h wdata=%h dout=%h expected all 0",
                     data_m_ack, ram_wr_en, ram_addr, ram_wdata, data_m_data_out);
        else n_pass++;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (data_m_ack) acks++;
            if (ram_wr_en)  wes++;
        end
        data_m_access = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            if (data_m_ack) acks++;
            if (ram_wr_en)  wes++;
        end
        n_total++;
        if (acks !== 0 || wes !== 0 || mem[9] !== 16'h4321)
            $display("FAIL rst_abandon acks=%0d wes=%0d mem9=%h expected 0/0/4321", acks, wes, mem[9]);
        else n_pass++;
        run_access(1'b0, 13'd9, 2'b11, 16'h0, an, wn);
        n_total++;
        if (an !== 3 || data_m_data_out !== 16'h4321) $display("FAIL rst_recover ack=%0d data=%h expected 3/4321", an, data_m_data_out);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; data_m_access = 1'b0; data_m_wr_en = 1'b0;
        data_m_addr = '0; data_m_bytesel = 2'b00; data_m_data_in = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        #12;
        test_reset_values();
        preload(13'd0, 16'h0A0B);
        preload(AB'(WORDS - 1), 16'hF00D);
        preload(13'd7, 16'h1234);
        preload(13'd3, 16'h3333);
        preload(13'd9, 16'h4321);
        @(negedge clk);
        reset = 1'b0;
        test_full_write_read();
        test_partial_write();
        test_noop_cs();
        test_back_to_back();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dpram_bus_port.md
# dpram_bus_port

Single-client bus responder that drives one port of the dual-port RAM from the CPU-style memory bus. It converts access/ack bus transactions into RAM port cycles, accounts for the RAM's one-cycle registered read latency, and implements byte-lane writes as read-modify-write, because the RAM port has no byte enables. Two instances, one per RAM port, serve two independent bus masters.

## Interface

Parameters:
- `words`, default 8192: RAM depth in 16-bit words. `addr_bits = $clog2(words)`.

Ports (clock and reset first):
- `clk`  in  1: single clock for the block.
- `reset`  in  1: asynchronous, active-high reset.
- `cs`  in  1: chip select. Access is ignored unless high.
- `data_m_access`  in  1: bus request. Held high until ack is seen.
- `data_m_ack`  out  1: one-cycle completion pulse.
- `data_m_wr_en`  in  1: 1 = write, 0 = read.
- `data_m_addr`  in  addr_bits: word address.
- `data_m_bytesel`  in  2: bit0 selects [7:0], bit1 selects [15:8].
- `data_m_data_in`  in  16: write data.
- `data_m_data_out`  out  16: read data. Valid with ack and held until the next read completes.
- `ram_addr`  out  addr_bits: RAM port address.
- `ram_wr_en`  out  1: RAM port write enable.
- `ram_wdata`  out  16: RAM port write data.
- `ram_q`  in  16: RAM port read data, valid one cycle after the address is presented.

## Operation

- States: IDLE, RD, WAIT, WR, ACK.
- **IDLE**
  - When `cs && data_m_access` are sampled high, capture addr, wr_en, bytesel and data_in into request registers.
  - Next state:
    - Read, or write with bytesel 01 or 10 → RD.
    - Write with bytesel 11 or 00 → WR.
- **RD**
  - `ram_addr` = captured address.
  - The RAM registers the read data at the end of this cycle.
  - Next state: WAIT.
- **WAIT**
  - `ram_q` is valid.
  - Read: `data_m_data_out <= ram_q`, `data_m_ack <= 1`, next state ACK.
  - Partial write: build the merge register per lane.
    - Lane taken from `data_in` when its bytesel bit = 1.
    - Lane taken from `ram_q` otherwise.
    - Next state: WR.
- **WR**
  - `ram_wr_en` = 1 only if bytesel != 00. It is combinational from state, so it drops immediately on reset.
  - `ram_wdata`:
    - bytesel 11: captured data_in.
    - Partial write: merge register.
  - `data_m_ack <= 1`. Next state: ACK.
- **ACK**
  - `data_m_ack` is high for this cycle only and is cleared at the end of it.
  - Access is not sampled in this state, so a still-high access is not re-accepted.
  - Next state: IDLE.
- `ram_addr` holds the captured address from RD through ACK. In IDLE it holds its last value.
- `data_m_data_out` is unchanged by writes.
- A bytesel 00 write is acknowledged and leaves the RAM untouched.
- A bytesel 00 read is a normal full-word read.
- Address and data inputs may change after capture without affecting the in-flight transaction.

## Timing

- Latencies, with the request sampled at edge k in IDLE:
  - Read: ack and data_out valid in cycle k+3.
  - Full write (11) or 00 write: RAM write in cycle k+1, ack in cycle k+2.
  - Partial write: RAM read in k+1, merge in k+2, write in k+3, ack in k+4.
- Back-to-back requests: the earliest next sample is the IDLE cycle after ACK, i.e. ack cycle + 1.
- Reset:
  - Async assert forces state IDLE.
  - Outputs reset to: `data_m_ack` = 0, `data_m_data_out` = 0x0000, `ram_wr_en` = 0, `ram_addr` = 0, `ram_wdata` = 0x0000.
  - A request in flight is abandoned: no RAM write and no ack.
  - The first request is sampled at the first rising edge after deassert.
- `cs` low with access high leaves the block in IDLE with no RAM activity.

## Test plan

- **Reset:** assert reset mid-partial-write (state WAIT). Expect `ram_wr_en` to stay 0, ack never to pulse, and the RAM word unchanged; all outputs read 0.
- **Full write then read:** write 0xBEEF to addr 5 with bytesel 11, expecting ack at k+2. Read addr 5, expecting `data_out` = 0xBEEF with ack at k+3.
- **Partial writes:** with RAM[7] = 0x1234, write 0xAACC bytesel 01 → RAM[7] = 0x12CC. Then write 0x55xx bytesel 10 → RAM[7] = 0x55CC. Each ack is at k+4.
- **No-op and chip select:** a bytesel 00 write to addr 3 (0x9999) acks at k+2 with RAM[3] unchanged. An access with `cs` = 0 produces no ack and no `ram_wr_en` for 10 cycles.
- **Held access and back-to-back reads:** hold access high through ack. Expect exactly one ack per transaction and a second read accepted at ack + 1. Read data from consecutive addresses 0 and `words-1` must be correct, covering the top address.
